// File: rtl/sys_pwr_seq.sv
// ---------------------------------------------------------------------------
// sys_pwr_seq
//   Power sequencer between a processor core, the HCLK clock controller and
//   the system reset generator. Gates HCLK after a stable deep-sleep period,
//   re-enables it on wake with a settle delay, and stretches core reset
//   requests (SYSRESETREQ, or LOCKUP when enabled) to a minimum hold time.
//
//   Build option:
//     PWR_SEQ_SLEEP_CNT_EN  when defined, SLEEP_CNT counts entries into GATED
//                           (saturating); otherwise SLEEP_CNT is tied to 0.
//
//   Parameters:
//     GATE_DLY    FCLK cycles of stable deep sleep before HCLK is gated (1..256)
//     UNGATE_DLY  FCLK cycles HCLK runs before returning to RUN (1..256)
//     RST_HOLD    minimum FCLK cycles SYSRST_OUT is held (1..256)
//
//   Ports:
//     FCLK           in   free-running clock, the block's only clock
//     PORESET        in   synchronous active-high reset
//     SLEEPING       in   core sleep status
//     SLEEPDEEP      in   core deep-sleep status
//     WAKEUP         in   wake request from the wake-up interrupt controller
//     SYSRESETREQ    in   core system-reset request
//     LOCKUP         in   core lockup status
//     LOCKUP_RST_EN  in   treat LOCKUP as a reset request
//     GATEHCLK       out  registered request to stop HCLK
//     SYSRST_OUT     out  registered system-reset request
//     STATE[2:0]     out  current state encoding
//     SLEEP_CNT[15:0] out count of GATED entries
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   RUN (0)     | core running, HCLK on
//   SLEEP_DLY(1)| deep sleep seen, waiting GATE_DLY cycles before gating
//   GATED (2)   | HCLK gated, waiting for wake
//   UNGATE (3)  | HCLK restarted, settling UNGATE_DLY cycles
//   RST_HOLD(4) | system reset asserted, held at least RST_HOLD cycles
// ---------------------------------------------------------------------------
module sys_pwr_seq #(
  parameter int unsigned GATE_DLY   = 4,
  parameter int unsigned UNGATE_DLY = 2,
  parameter int unsigned RST_HOLD   = 16
) (
  input  logic        FCLK,
  input  logic        PORESET,
  input  logic        SLEEPING,
  input  logic        SLEEPDEEP,
  input  logic        WAKEUP,
  input  logic        SYSRESETREQ,
  input  logic        LOCKUP,
  input  logic        LOCKUP_RST_EN,
  output logic        GATEHCLK,
  output logic        SYSRST_OUT,
  output logic [2:0]  STATE,
  output logic [15:0] SLEEP_CNT
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SLEEP_DLY = 3'd1,
    ST_GATED     = 3'd2,
    ST_UNGATE    = 3'd3,
    ST_RST_HOLD  = 3'd4
  } state_t;

  // Load values are parameter-1 truncated to 8 bits, so 256 loads 8'hFF.
  localparam logic [7:0] GATE_LD   = 8'(GATE_DLY - 1);
  localparam logic [7:0] UNGATE_LD = 8'(UNGATE_DLY - 1);
  localparam logic [7:0] RST_LD    = 8'(RST_HOLD - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       rstreq;
  logic       wake;

  assign rstreq = SYSRESETREQ | (LOCKUP & LOCKUP_RST_EN);
  assign wake   = WAKEUP | ~SLEEPING;
  assign STATE  = state;

`ifdef PWR_SEQ_SLEEP_CNT_EN
  logic [15:0] sleep_cnt_q;
  assign SLEEP_CNT = sleep_cnt_q;
`else
  assign SLEEP_CNT = 16'h0000;
`endif

  // Outputs are written alongside every state change so they always match
  // the state register without a decode stage.
  always_ff @(posedge FCLK) begin
    if (PORESET) begin
      state      <= ST_RUN;
      cnt        <= 8'd0;
      GATEHCLK   <= 1'b0;
      SYSRST_OUT <= 1'b0;
`ifdef PWR_SEQ_SLEEP_CNT_EN
      sleep_cnt_q <= 16'h0000;
`endif
    end else if (rstreq && (state != ST_RST_HOLD)) begin
      // Reset requests beat everything else, including an active gate.
      state      <= ST_RST_HOLD;
      cnt        <= RST_LD;
      GATEHCLK   <= 1'b0;
      SYSRST_OUT <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          // Wake in the same cycle as the sleep condition keeps us in RUN.
          if (SLEEPING && SLEEPDEEP && !WAKEUP) begin
            state <= ST_SLEEP_DLY;
            cnt   <= GATE_LD;
          end
        end
        ST_SLEEP_DLY: begin
          if (wake) begin
            state <= ST_RUN;
          end else if (cnt == 8'd0) begin
            state    <= ST_GATED;
            GATEHCLK <= 1'b1;
`ifdef PWR_SEQ_SLEEP_CNT_EN
            if (sleep_cnt_q != 16'hFFFF) sleep_cnt_q <= sleep_cnt_q + 16'd1;
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_GATED: begin
          if (wake) begin
            state    <= ST_UNGATE;
            cnt      <= UNGATE_LD;
            GATEHCLK <= 1'b0;
          end
        end
        ST_UNGATE: begin
          // Wake/sleep inputs are ignored while HCLK settles.
          if (cnt == 8'd0) state <= ST_RUN;
          else             cnt   <= cnt - 8'd1;
        end
        ST_RST_HOLD: begin
          // Counter saturates at 0; a still-asserted request extends the hold.
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!rstreq) begin
            state      <= ST_RUN;
            SYSRST_OUT <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          cnt        <= 8'd0;
          GATEHCLK   <= 1'b0;
          SYSRST_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_pwr_seq.sv
module tb_sys_pwr_seq;

  logic        FCLK = 1'b0;
  logic        PORESET = 1'b1;
  logic        SLEEPING = 1'b0;
  logic        SLEEPDEEP = 1'b0;
  logic        WAKEUP = 1'b0;
  logic        SYSRESETREQ = 1'b0;
  logic        LOCKUP = 1'b0;
  logic        LOCKUP_RST_EN = 1'b0;
  logic        GATEHCLK;
  logic        SYSRST_OUT;
  logic [2:0]  STATE;
  logic [15:0] SLEEP_CNT;

  int total = 0;
  int bad = 0;
  int exp_sleep = 0;

  sys_pwr_seq dut (
    .FCLK(FCLK),
    .PORESET(PORESET),
    .SLEEPING(SLEEPING),
    .SLEEPDEEP(SLEEPDEEP),
    .WAKEUP(WAKEUP),
    .SYSRESETREQ(SYSRESETREQ),
    .LOCKUP(LOCKUP),
    .LOCKUP_RST_EN(LOCKUP_RST_EN),
    .GATEHCLK(GATEHCLK),
    .SYSRST_OUT(SYSRST_OUT),
    .STATE(STATE),
    .SLEEP_CNT(SLEEP_CNT)
  );

  always #5 FCLK = ~FCLK;

  // Sample 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  function automatic logic [15:0] exp_sc();
`ifdef PWR_SEQ_SLEEP_CNT_EN
    return 16'(exp_sleep);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic test_reset();
    PORESET = 1'b1;
    tick(); tick();
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", STATE); end
    total++; if (GATEHCLK !== 1'b0) begin bad++; $display("FAIL reset_gate got=%b exp=0", GATEHCLK); end
    total++; if (SYSRST_OUT !== 1'b0) begin bad++; $display("FAIL reset_rst got=%b exp=0", SYSRST_OUT); end
    total++; if (SLEEP_CNT !== 16'h0) begin bad++; $display("FAIL reset_scnt got=%0d exp=0", SLEEP_CNT); end
    PORESET = 1'b0;
    exp_sleep = 0;
  endtask

  task automatic test_deep_sleep();
    SLEEPING = 1'b1; SLEEPDEEP = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      total++; if (STATE !== ((e < 5) ? 3'd1 : 3'd2)) begin bad++; $display("FAIL deep_state edge=%0d got=%0d exp=%0d", e, STATE, (e < 5) ? 1 : 2); end
      total++; if (GATEHCLK !== (e == 5)) begin bad++; $display("FAIL deep_gate edge=%0d got=%b exp=%b", e, GATEHCLK, e == 5); end
    end
    exp_sleep++;
    total++; if (SLEEP_CNT !== exp_sc()) begin bad++; $display("FAIL deep_scnt got=%0d exp=%0d", SLEEP_CNT, exp_sc()); end
  endtask

  task automatic test_wake();
    WAKEUP = 1'b1;
    tick();
    total++; if (STATE !== 3'd3) begin bad++; $display("FAIL wake_state1 got=%0d exp=3", STATE); end
    total++; if (GATEHCLK !== 1'b0) begin bad++; $display("FAIL wake_gate got=%b exp=0", GATEHCLK); end
    WAKEUP = 1'b0; SLEEPING = 1'b0; SLEEPDEEP = 1'b0;
    tick();
    total++; if (STATE !== 3'd3) begin bad++; $display("FAIL wake_state2 got=%0d exp=3", STATE); end
    tick();
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL wake_run got=%0d exp=0", STATE); end
  endtask

  task automatic test_sleep_abort();
    int gate_seen = 0;
    SLEEPING = 1'b1; SLEEPDEEP = 1'b1;
    tick(); tick();
    total++; if (STATE !== 3'd1) begin bad++; $display("FAIL abort_pre got=%0d exp=1", STATE); end
    SLEEPING = 1'b0;
    tick();
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", STATE); end
    for (int i = 0; i < 6; i++) begin
      if (GATEHCLK) gate_seen++;
      tick();
    end
    SLEEPDEEP = 1'b0;
    total++; if (gate_seen !== 0) begin bad++; $display("FAIL abort_gate got=%0d exp=0", gate_seen); end
    total++; if (SLEEP_CNT !== exp_sc()) begin bad++; $display("FAIL abort_scnt got=%0d exp=%0d", SLEEP_CNT, exp_sc()); end
  endtask

  task automatic test_normal_sleep();
    int odd = 0;
    SLEEPING = 1'b1; SLEEPDEEP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (STATE !== 3'd0 || GATEHCLK !== 1'b0) odd++;
    end
    SLEEPING = 1'b0;
    total++; if (odd !== 0) begin bad++; $display("FAIL normal_sleep got=%0d exp=0", odd); end
  endtask

  task automatic test_wake_priority();
    SLEEPING = 1'b1; SLEEPDEEP = 1'b1; WAKEUP = 1'b1;
    tick();
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL wake_prio got=%0d exp=0", STATE); end
    SLEEPING = 1'b0; SLEEPDEEP = 1'b0; WAKEUP = 1'b0;
    tick();
  endtask

  task automatic test_sysreset(input int hold, input int exp_hi);
    int hi = 0;
    int last = -1;
    SYSRESETREQ = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == hold - 1) SYSRESETREQ = 1'b0;
      if (SYSRST_OUT) begin hi++; last = i; end
    end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL rst_len hold=%0d got=%0d exp=%0d", hold, hi, exp_hi); end
    total++; if (last !== exp_hi - 1) begin bad++; $display("FAIL rst_last hold=%0d got=%0d exp=%0d", hold, last, exp_hi - 1); end
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL rst_exit hold=%0d got=%0d exp=0", hold, STATE); end
  endtask

  task automatic test_lockup();
    int moved = 0;
    LOCKUP = 1'b1; LOCKUP_RST_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (STATE !== 3'd0 || SYSRST_OUT !== 1'b0) moved++;
    end
    total++; if (moved !== 0) begin bad++; $display("FAIL lock_noen got=%0d exp=0", moved); end
    SLEEPING = 1'b1; SLEEPDEEP = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    exp_sleep++;
    total++; if (STATE !== 3'd2) begin bad++; $display("FAIL lock_gated got=%0d exp=2", STATE); end
    LOCKUP_RST_EN = 1'b1;
    tick();
    total++; if (STATE !== 3'd4) begin bad++; $display("FAIL lock_state got=%0d exp=4", STATE); end
    total++; if (GATEHCLK !== 1'b0) begin bad++; $display("FAIL lock_gate got=%b exp=0", GATEHCLK); end
    total++; if (SYSRST_OUT !== 1'b1) begin bad++; $display("FAIL lock_rst got=%b exp=1", SYSRST_OUT); end
    LOCKUP = 1'b0; LOCKUP_RST_EN = 1'b0; SLEEPING = 1'b0; SLEEPDEEP = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++; if (STATE !== 3'd4) begin bad++; $display("FAIL lock_hold got=%0d exp=4", STATE); end
    tick();
    total++; if (STATE !== 3'd0 || SYSRST_OUT !== 1'b0) begin bad++; $display("FAIL lock_exit got=%0d/%b exp=0/0", STATE, SYSRST_OUT); end
    total++; if (SLEEP_CNT !== exp_sc()) begin bad++; $display("FAIL lock_scnt got=%0d exp=%0d", SLEEP_CNT, exp_sc()); end
  endtask

  task automatic test_por_mid();
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total++; if (STATE !== 3'd4) begin bad++; $display("FAIL por_pre got=%0d exp=4", STATE); end
    PORESET = 1'b1;
    tick();
    exp_sleep = 0;
    total++; if (STATE !== 3'd0 || SYSRST_OUT !== 1'b0 || GATEHCLK !== 1'b0 || SLEEP_CNT !== 16'h0)
      begin bad++; $display("FAIL por_hold got=%0d/%b/%b/%0d exp=0/0/0/0", STATE, SYSRST_OUT, GATEHCLK, SLEEP_CNT); end
    PORESET = 1'b0;
    SLEEPING = 1'b1; SLEEPDEEP = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    exp_sleep++;
    total++; if (GATEHCLK !== 1'b1 || SLEEP_CNT !== exp_sc()) begin bad++; $display("FAIL por_gpre got=%b/%0d exp=1/%0d", GATEHCLK, SLEEP_CNT, exp_sc()); end
    PORESET = 1'b1;
    tick();
    exp_sleep = 0;
    total++; if (STATE !== 3'd0 || GATEHCLK !== 1'b0 || SLEEP_CNT !== 16'h0)
      begin bad++; $display("FAIL por_gated got=%0d/%b/%0d exp=0/0/0", STATE, GATEHCLK, SLEEP_CNT); end
    PORESET = 1'b0; SLEEPING = 1'b0; SLEEPDEEP = 1'b0;
    tick();
  endtask

  task automatic test_sleep_cnt();
    for (int k = 0; k < 3; k++) begin
      SLEEPING = 1'b1; SLEEPDEEP = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      exp_sleep++;
      SLEEPING = 1'b0; SLEEPDEEP = 1'b0;
      for (int i = 0; i < 3; i++) tick();
    end
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL scnt_state got=%0d exp=0", STATE); end
    total++; if (SLEEP_CNT !== exp_sc()) begin bad++; $display("FAIL scnt_val got=%0d exp=%0d", SLEEP_CNT, exp_sc()); end
  endtask

  initial begin
    test_reset();
    test_deep_sleep();
    test_wake();
    test_sleep_abort();
    test_normal_sleep();
    test_wake_priority();
    test_sysreset(3, 16);
    test_sysreset(30, 30);
    test_lockup();
    test_por_mid();
    test_sleep_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
